// File: rtl/chord_stream_top.sv
// rtl/chord_stream_top.sv - backpressure-capable CORDIC vectoring accelerator top
//
// Purpose: accepts packed {y, x} operands with a ready/valid handshake, runs
// them through a fixed-latency, non-stallable CORDIC vectoring pipeline and
// buffers results in a FIFO. The bus side sees the FIFO head through a
// first-word-fall-through output register. A credit counter (inflight) keeps
// inflight + fifo_level <= FIFO_DEPTH, so the pipeline always has a FIFO slot
// for each result it produces.
//
// Optional feature macro: CHORD_STREAM_PERF_EN (adds saturating perf counters).
//
// Ports:
//   clk                 in   single clock
//   reset               in   synchronous, active-low reset
//   in_interface        in   32  operand word {y[31:16], x[15:0]} (two's complement)
//   valid_in_interface  in   1   operand valid
//   ready_in_interface  out  1   block can accept an operand
//   out_interface       out  32  result word {angle[31:16], magnitude[15:0]}
//   valid_out_interface out  1   result valid
//   ready_out_interface in   1   consumer accepts the result
//   fifo_level          out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//   overflow_err        out  1   sticky: FIFO write while full (unreachable)
//   perf_accept_cnt     out  32  (CHORD_STREAM_PERF_EN) accepted operands
//   perf_stall_cnt      out  32  (CHORD_STREAM_PERF_EN) valid_in && !ready_in cycles
//   perf_hold_cnt       out  32  (CHORD_STREAM_PERF_EN) valid_out && !ready_out cycles

module chord_stream_top #(
   parameter int INPUT_WIDTH          = 16,
   parameter int OUTPUT_WIDTH         = 16,
   parameter int ITERATION_NUMBER     = 6,
   parameter int ITERATION_WORD_WIDTH = 32,
   parameter int FLIP_FLAG_WIDTH      = 1,
   parameter int PIPE_LATENCY         = 8,
   parameter int FIFO_DEPTH           = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [31:0]                     in_interface,
   input  logic                            valid_in_interface,
   output logic                            ready_in_interface,
   output logic [31:0]                     out_interface,
   output logic                            valid_out_interface,
   input  logic                            ready_out_interface,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow_err
`ifdef CHORD_STREAM_PERF_EN
   ,
   output logic [31:0]                     perf_accept_cnt,
   output logic [31:0]                     perf_stall_cnt,
   output logic [31:0]                     perf_hold_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int W  = ITERATION_WORD_WIDTH;

   logic signed [W-1:0]        op_x, op_y;
   logic signed [W-1:0]        pipe_x, pipe_z;
   logic [FLIP_FLAG_WIDTH-1:0] pipe_flip;
   logic                       pipe_valid;
   logic [31:0]                res_word;

   logic [LW-1:0] inflight;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   mem [FIFO_DEPTH];
   logic          accept, pop, full, wr_en;
   logic          unused_pipe_bits;

   // Credits: every accepted operand owns a FIFO slot until it is popped.
   assign ready_in_interface = reset &&
      (({1'b0, inflight} + {1'b0, fifo_level}) < (LW+1)'(FIFO_DEPTH));
   assign accept = valid_in_interface && ready_in_interface;
   assign pop    = valid_out_interface && ready_out_interface;
   assign full   = (fifo_level == LW'(FIFO_DEPTH));
   // A write into a full FIFO is legal only when the head leaves the same cycle.
   assign wr_en  = pipe_valid && (!full || pop);

   interface_input #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .W           (W)
   ) u_interface_input (
      .in_word (in_interface),
      .x       (op_x),
      .y       (op_y)
   );

   pipeline #(
      .ITERATION_NUMBER     (ITERATION_NUMBER),
      .ITERATION_WORD_WIDTH (W),
      .FLIP_FLAG_WIDTH      (FLIP_FLAG_WIDTH),
      .PIPE_LATENCY         (PIPE_LATENCY)
   ) u_pipeline (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (accept),
      .x_in      (op_x),
      .y_in      (op_y),
      .valid_out (pipe_valid),
      .x_out     (pipe_x),
      .z_out     (pipe_z),
      .flip_out  (pipe_flip)
   );

   interface_output #(
      .OUTPUT_WIDTH (OUTPUT_WIDTH)
   ) u_interface_output (
      .mag      (pipe_x[OUTPUT_WIDTH-1:0]),
      .angle    (pipe_z[OUTPUT_WIDTH-1:0]),
      .flip     (pipe_flip[0]),
      .out_word (res_word)
   );

   assign unused_pipe_bits = ^{pipe_x[W-1:OUTPUT_WIDTH], pipe_z[W-1:OUTPUT_WIDTH]};

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= res_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         inflight            <= '0;
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         fifo_level          <= '0;
         overflow_err        <= 1'b0;
         valid_out_interface <= 1'b0;
         out_interface       <= '0;
      end else begin
         inflight   <= inflight + LW'(accept) - LW'(pipe_valid);
         wr_ptr     <= wr_ptr + AW'(wr_en);
         rd_ptr     <= rd_ptr + AW'(pop);
         fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
         if (pipe_valid && full && !pop) begin
            overflow_err <= 1'b1;
         end
         // The output register mirrors the FIFO head; the entry stays counted
         // in fifo_level until the consumer pops it. Only entries already in
         // memory before this edge are eligible, so a same-cycle write is
         // picked up one cycle later.
         if (!valid_out_interface || pop) begin
            if (fifo_level > LW'(pop)) begin
               out_interface       <= mem[rd_ptr + AW'(pop)];
               valid_out_interface <= 1'b1;
            end else begin
               valid_out_interface <= 1'b0;
            end
         end
      end
   end

`ifdef CHORD_STREAM_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_accept_cnt <= '0;
         perf_stall_cnt  <= '0;
         perf_hold_cnt   <= '0;
      end else begin
         if (accept && (perf_accept_cnt != '1)) begin
            perf_accept_cnt <= perf_accept_cnt + 32'd1;
         end
         if (valid_in_interface && !ready_in_interface && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (valid_out_interface && !ready_out_interface && (perf_hold_cnt != '1)) begin
            perf_hold_cnt <= perf_hold_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// Operand unpack: {y, x} two's complement, sign-extended to the iteration word.
module interface_input #(
   parameter int INPUT_WIDTH = 16,
   parameter int W           = 32
) (
   input  logic [31:0]         in_word,
   output logic signed [W-1:0] x,
   output logic signed [W-1:0] y
);
   assign x = {{(W-INPUT_WIDTH){in_word[INPUT_WIDTH-1]}}, in_word[INPUT_WIDTH-1:0]};
   assign y = {{(W-INPUT_WIDTH){in_word[2*INPUT_WIDTH-1]}}, in_word[2*INPUT_WIDTH-1:INPUT_WIDTH]};
endmodule

// Fixed-latency vectoring CORDIC. Stage 0 captures, stage 1 folds the left
// half-plane onto the right (flip flag = +180 degrees), stages 2.. run the
// micro-rotations, any remaining stages only delay. Needs
// PIPE_LATENCY >= ITERATION_NUMBER + 2. Angles are in units of 1/65536 turn.
module pipeline #(
   parameter int ITERATION_NUMBER     = 6,
   parameter int ITERATION_WORD_WIDTH = 32,
   parameter int FLIP_FLAG_WIDTH      = 1,
   parameter int PIPE_LATENCY         = 8
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   valid_in,
   input  logic signed [ITERATION_WORD_WIDTH-1:0] x_in,
   input  logic signed [ITERATION_WORD_WIDTH-1:0] y_in,
   output logic                                   valid_out,
   output logic signed [ITERATION_WORD_WIDTH-1:0] x_out,
   output logic signed [ITERATION_WORD_WIDTH-1:0] z_out,
   output logic [FLIP_FLAG_WIDTH-1:0]             flip_out
);
   localparam int W = ITERATION_WORD_WIDTH;

   logic [PIPE_LATENCY-1:0]    v;
   logic signed [W-1:0]        xs [PIPE_LATENCY];
   logic signed [W-1:0]        ys [PIPE_LATENCY];
   logic signed [W-1:0]        zs [PIPE_LATENCY];
   logic [FLIP_FLAG_WIDTH-1:0] fs [PIPE_LATENCY];

   function automatic int atan_lut(input int i);
      case (i)
         0:  return 8192;
         1:  return 4836;
         2:  return 2555;
         3:  return 1297;
         4:  return 651;
         5:  return 326;
         6:  return 163;
         7:  return 81;
         8:  return 41;
         9:  return 20;
         10: return 10;
         11: return 5;
         12: return 3;
         13: return 1;
         14: return 1;
         default: return 0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         v <= '0;
      end else begin
         v <= {v[PIPE_LATENCY-2:0], valid_in};
      end
   end

   always_ff @(posedge clk) begin
      xs[0] <= x_in;
      ys[0] <= y_in;
      zs[0] <= '0;
      fs[0] <= '0;
      if (xs[0][W-1]) begin
         xs[1] <= -xs[0];
         ys[1] <= -ys[0];
         fs[1] <= FLIP_FLAG_WIDTH'(1);
      end else begin
         xs[1] <= xs[0];
         ys[1] <= ys[0];
         fs[1] <= '0;
      end
      zs[1] <= zs[0];
      for (int s = 2; s < PIPE_LATENCY; s++) begin
         fs[s] <= fs[s-1];
         if (s - 2 < ITERATION_NUMBER) begin
            // Rotate toward the x axis: y >= 0 rotates clockwise.
            if (!ys[s-1][W-1]) begin
               xs[s] <= xs[s-1] + (ys[s-1] >>> (s-2));
               ys[s] <= ys[s-1] - (xs[s-1] >>> (s-2));
               zs[s] <= zs[s-1] + W'(atan_lut(s-2));
            end else begin
               xs[s] <= xs[s-1] - (ys[s-1] >>> (s-2));
               ys[s] <= ys[s-1] + (xs[s-1] >>> (s-2));
               zs[s] <= zs[s-1] - W'(atan_lut(s-2));
            end
         end else begin
            xs[s] <= xs[s-1];
            ys[s] <= ys[s-1];
            zs[s] <= zs[s-1];
         end
      end
   end

   assign valid_out = v[PIPE_LATENCY-1];
   assign x_out     = xs[PIPE_LATENCY-1];
   assign z_out     = zs[PIPE_LATENCY-1];
   assign flip_out  = fs[PIPE_LATENCY-1];
endmodule

// Result pack: {angle, magnitude}; the flip flag adds half a turn.
module interface_output #(
   parameter int OUTPUT_WIDTH = 16
) (
   input  logic [OUTPUT_WIDTH-1:0] mag,
   input  logic [OUTPUT_WIDTH-1:0] angle,
   input  logic                    flip,
   output logic [31:0]             out_word
);
   localparam logic [OUTPUT_WIDTH-1:0] HALF_TURN = OUTPUT_WIDTH'(1) << (OUTPUT_WIDTH-1);

   assign out_word = 32'({angle + (flip ? HALF_TURN : '0), mag});
endmodule

// File: tb/tb_chord_stream_top.sv
// tb/tb_chord_stream_top.sv - randomized scoreboard bench for chord_stream_top

module tb_chord_stream_top;

   localparam int PL    = 8;
   localparam int DEPTH = 16;
   localparam int ITER  = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] in_interface = '0;
   logic        valid_in_interface = 1'b0;
   logic        ready_in_interface;
   logic [31:0] out_interface;
   logic        valid_out_interface;
   logic        ready_out_interface = 1'b0;
   logic [4:0]  fifo_level;
   logic        overflow_err;
`ifdef CHORD_STREAM_PERF_EN
   logic [31:0] perf_accept_cnt, perf_stall_cnt, perf_hold_cnt;
`endif

   chord_stream_top dut (
      .clk                 (clk),
      .reset               (reset),
      .in_interface        (in_interface),
      .valid_in_interface  (valid_in_interface),
      .ready_in_interface  (ready_in_interface),
      .out_interface       (out_interface),
      .valid_out_interface (valid_out_interface),
      .ready_out_interface (ready_out_interface),
      .fifo_level          (fifo_level),
      .overflow_err        (overflow_err)
`ifdef CHORD_STREAM_PERF_EN
      ,
      .perf_accept_cnt     (perf_accept_cnt),
      .perf_stall_cnt      (perf_stall_cnt),
      .perf_hold_cnt       (perf_hold_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Golden vectoring CORDIC: fold to right half-plane, then ITER micro-rotations.
   int atan_tab [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

   function automatic logic [31:0] ref_word(input logic [31:0] w);
      longint x, y, z, nx;
      logic [15:0] xs, ys;
      bit flip;
      xs = w[15:0];
      ys = w[31:16];
      x = longint'($signed(xs));
      y = longint'($signed(ys));
      z = 0;
      flip = 0;
      if (x < 0) begin
         x = -x;
         y = -y;
         flip = 1;
      end
      for (int i = 0; i < ITER; i++) begin
         if (y >= 0) begin
            nx = x + (y >>> i);
            y  = y - (x >>> i);
            z  = z + atan_tab[i];
         end else begin
            nx = x - (y >>> i);
            y  = y + (x >>> i);
            z  = z - atan_tab[i];
         end
         x = nx;
      end
      if (flip) z = z + 32768;
      return {z[15:0], x[15:0]};
   endfunction

   // Scoreboard: outstanding = accepted - popped must bound ready_in.
   logic [31:0] exp_q [$];
   int          outstanding = 0;
   int          pops = 0;
   bit          hold_prev = 0;
   logic [31:0] hold_data = '0;

   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         outstanding = 0;
         hold_prev = 0;
      end else begin
         chk("ready_credit", ready_in_interface, outstanding < DEPTH);
         if (hold_prev) begin
            chk("hold_valid", valid_out_interface, 1);
            chk("hold_data", out_interface, hold_data);
         end
         if (valid_in_interface && ready_in_interface) begin
            exp_q.push_back(ref_word(in_interface));
            outstanding++;
         end
         if (valid_out_interface && ready_out_interface) begin
            chk("pop_has_entry", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("result_order", out_interface, exp_q.pop_front());
            outstanding--;
            pops++;
         end
         hold_prev = valid_out_interface && !ready_out_interface;
         hold_data = out_interface;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int first, last, nres, acc, p0, drops, stale, cyc;

      // Reset state
      reset = 1'b0;
      step();
      step();
      chk("rst_ready_low", ready_in_interface, 0);
      chk("rst_valid_out", valid_out_interface, 0);
      chk("rst_out", out_interface, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow_err, 0);
      reset = 1'b1;
      #1;
      chk("ready_after_reset", ready_in_interface, 1);

      // Single operand: latency, single pulse, hand-computed golden word
      ready_out_interface = 1'b1;
      in_interface = 32'h0000_0100;
      valid_in_interface = 1'b1;
      step();
      valid_in_interface = 1'b0;
      first = -1;
      nres = 0;
      for (int i = 1; i <= PL + 6; i++) begin
         step();
         if (valid_out_interface) begin
            nres++;
            if (first < 0) begin
               first = i;
               chk("single_result", out_interface, 32'hFF55_01A6);
            end
         end
      end
      chk("single_latency", first, PL + 1);
      chk("single_pulse_count", nres, 1);

      // 100 back-to-back operands
      first = -1;
      last = 0;
      nres = 0;
      drops = 0;
      for (int i = 0; i < 100 + PL + 10; i++) begin
         if (i < 100) begin
            valid_in_interface = 1'b1;
            in_interface = $urandom;
            if (!ready_in_interface) drops++;
         end else begin
            valid_in_interface = 1'b0;
         end
         step();
         if (valid_out_interface) begin
            nres++;
            if (first < 0) first = i;
            last = i;
         end
      end
      chk("b2b_count", nres, 100);
      chk("b2b_contiguous", last - first, 99);
      chk("b2b_ready_drops", drops, 0);

      // Full stall
      ready_out_interface = 1'b0;
      valid_in_interface = 1'b1;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         in_interface = $urandom;
         if (ready_in_interface) acc++;
         step();
      end
      chk("full_accepts", acc, DEPTH);
      chk("full_ready", ready_in_interface, 0);
      chk("full_level", fifo_level, DEPTH);
      chk("full_ovf", overflow_err, 0);
      chk("full_valid_out", valid_out_interface, 1);

      // One-cycle pop from full
      p0 = pops;
      ready_out_interface = 1'b1;
      step();
      ready_out_interface = 1'b0;
      chk("recover_ready_rise", ready_in_interface, 1);
      step();
      chk("recover_ready_fall", ready_in_interface, 0);
      chk("recover_one_pop", pops - p0, 1);
      valid_in_interface = 1'b0;
      repeat (PL + 2) step();
      chk("recover_level", fifo_level, DEPTH);
      chk("recover_ovf", overflow_err, 0);

      ready_out_interface = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      chk("drain_empty", exp_q.size(), 0);
      step();
      chk("drain_level", fifo_level, 0);

      // Reset with 5 in flight and 10 buffered
      ready_out_interface = 1'b0;
      valid_in_interface = 1'b1;
      for (int i = 0; i < 15; i++) begin
         in_interface = $urandom;
         step();
      end
      valid_in_interface = 1'b0;
      repeat (3) step();
      chk("pre_reset_level", fifo_level, 10);
      reset = 1'b0;
      step();
      chk("midrst_level", fifo_level, 0);
      chk("midrst_valid_out", valid_out_interface, 0);
      chk("midrst_ready_low", ready_in_interface, 0);
      reset = 1'b1;
      #1;
      chk("midrst_ready_high", ready_in_interface, 1);
      ready_out_interface = 1'b1;
      stale = 0;
      repeat (20) begin
         step();
         if (valid_out_interface) stale++;
      end
      chk("no_stale_valid", stale, 0);

      // Random valid/ready, 10k operands
      reset = 1'b0;
      step();
      reset = 1'b1;
      acc = 0;
      cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
         valid_in_interface = 1'($urandom_range(0, 1));
         in_interface = $urandom;
         ready_out_interface = 1'($urandom_range(0, 1));
         if (valid_in_interface && ready_in_interface) acc++;
         step();
         cyc++;
      end
      valid_in_interface = 1'b0;
      chk("rand_accepts", acc, 10000);
      ready_out_interface = 1'b1;
      for (int i = 0; i < 200 && (exp_q.size() != 0 || valid_out_interface); i++) step();
      chk("rand_drain", exp_q.size(), 0);
      chk("rand_ovf", overflow_err, 0);
`ifdef CHORD_STREAM_PERF_EN
      chk("perf_accept", perf_accept_cnt, 10000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
